// File: rtl/conv_pkg.sv
// conv_pkg: shared parameters and types for the conv readout path.
// Pixel triple, FSM state and a per-channel max helper.
package conv_pkg;

  localparam int DATA_W    = 8;
  localparam int IMG_W     = 8;
  localparam int OUT_W     = 6;
  localparam int FIRST_CNT = 20;
  localparam int CNT_W     = 7;
  localparam int FRAME_N   = OUT_W * OUT_W;
  localparam int PTR_W     = $clog2(FRAME_N);

  typedef enum logic {
    FILL,
    READ
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] d3;
  } pix_t;

  function automatic pix_t pix_max(pix_t a, pix_t b);
    pix_t r;
    r.d1 = (a.d1 > b.d1) ? a.d1 : b.d1;
    r.d2 = (a.d2 > b.d2) ? a.d2 : b.d2;
    r.d3 = (a.d3 > b.d3) ? a.d3 : b.d3;
    return r;
  endfunction

endpackage

// File: rtl/conv_readout_if.sv
// conv_readout_if: capture inputs from the conv storage side
// and the valid/ready stream towards the next layer.
interface conv_readout_if;
  import conv_pkg::*;

  logic              in_vld;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] conv_D1;
  logic [DATA_W-1:0] conv_D2;
  logic [DATA_W-1:0] conv_D3;
  logic              out_rdy;
  logic              out_vld;
  logic [DATA_W-1:0] out_D1;
  logic [DATA_W-1:0] out_D2;
  logic [DATA_W-1:0] out_D3;
  logic              out_last;
  logic              frame_done;
  logic              ovf;

  modport master (
    output in_vld, cnt, conv_D1, conv_D2, conv_D3, out_rdy,
    input  out_vld, out_D1, out_D2, out_D3,
    input  out_last, frame_done, ovf
  );

  modport slave (
    input  in_vld, cnt, conv_D1, conv_D2, conv_D3, out_rdy,
    output out_vld, out_D1, out_D2, out_D3,
    output out_last, frame_done, ovf
  );

endinterface

// File: rtl/conv_win_decode.sv
// conv_win_decode: maps the sequencer counter onto the conv
// output window (row/col inside the OUT_W x OUT_W frame).
module conv_win_decode
  import conv_pkg::*;
(
  input  logic [CNT_W-1:0] cnt_i,
  output logic             win_o,
  output logic [CNT_W-1:0] row_o,
  output logic [CNT_W-1:0] col_o
);

  logic [CNT_W-1:0] off;

  // unsigned offset from the first output, split into row/col
  always_comb begin
    off   = cnt_i - CNT_W'(FIRST_CNT);
    row_o = off / CNT_W'(IMG_W);
    col_o = off % CNT_W'(IMG_W);
    win_o = (cnt_i >= CNT_W'(FIRST_CNT)) &&
            (row_o < CNT_W'(OUT_W)) &&
            (col_o < CNT_W'(OUT_W));
  end

endmodule

// File: rtl/conv_readout.sv
// conv_readout: buffers one 6x6 three-channel conv frame, then streams it.
// CONV_READOUT_POOL_EN: stream 2x2 max-pooled beats instead of raw pixels.
module conv_readout
  import conv_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  conv_readout_if.slave  bus
);

`ifdef CONV_READOUT_POOL_EN
  localparam int RD_N = (OUT_W / 2) * (OUT_W / 2);
`else
  localparam int RD_N = FRAME_N;
`endif

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic             cap_q;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             we;
  logic             rd_act;
  logic             win;
  logic [CNT_W-1:0] row, col;
  logic             unused_rc;
  pix_t             in_pix, out_pix;
  pix_t             mem_q [FRAME_N];

  conv_win_decode u_win (
    .cnt_i (bus.cnt),
    .win_o (win),
    .row_o (row),
    .col_o (col)
  );

  assign unused_rc = ^{row, col};
  assign in_pix    = {bus.conv_D1, bus.conv_D2, bus.conv_D3};
  assign rd_act    = (state_q == READ);

  // storage register lags the window by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cap_q <= 1'b0;
    else     cap_q <= bus.in_vld && win;
  end

  // FSM state, pointers and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // frame buffer, contents need no reset
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_q] <= in_pix;
  end

  // next state: fill until a full frame, then drain it
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      FILL: begin
        if (cap_q) begin
          we = 1'b1;
          if (wr_q == PTR_W'(FRAME_N - 1)) begin
            wr_d    = '0;
            state_d = READ;
          end else begin
            wr_d = wr_q + PTR_W'(1);
          end
        end
      end
      READ: begin
        if (cap_q) ovf_d = 1'b1;
        if (bus.out_rdy) begin
          if (rd_q == PTR_W'(RD_N - 1)) begin
            rd_d    = '0;
            state_d = FILL;
            done_d  = 1'b1;
          end else begin
            rd_d = rd_q + PTR_W'(1);
          end
        end
      end
    endcase
  end

`ifdef CONV_READOUT_POOL_EN
  logic [PTR_W-1:0] base;

  // top-left of the 2x2 block for beat rd_q, then per-channel max
  always_comb begin
    base = PTR_W'(2 * OUT_W * (int'(rd_q) / (OUT_W / 2)) +
                  2 * (int'(rd_q) % (OUT_W / 2)));
    out_pix = pix_max(
      pix_max(mem_q[base], mem_q[base + PTR_W'(1)]),
      pix_max(mem_q[base + PTR_W'(OUT_W)],
              mem_q[base + PTR_W'(OUT_W + 1)]));
  end
`else
  assign out_pix = mem_q[rd_q];
`endif

  assign bus.out_vld    = rd_act;
  assign bus.out_last   = rd_act && (rd_q == PTR_W'(RD_N - 1));
  assign bus.out_D1     = rd_act ? out_pix.d1 : '0;
  assign bus.out_D2     = rd_act ? out_pix.d2 : '0;
  assign bus.out_D3     = rd_act ? out_pix.d3 : '0;
  assign bus.frame_done = done_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_conv_readout.sv
// tb_conv_readout: randomized sweeps against a frame-level model.
// Honours CONV_READOUT_POOL_EN for the pooled beat sequence.
module tb_conv_readout;
  import conv_pkg::*;

`ifdef CONV_READOUT_POOL_EN
  localparam int NB = (OUT_W / 2) * (OUT_W / 2);
  localparam int B0 = 29;
  localparam int BI = 1;
  localparam int BM = 31;
`else
  localparam int NB = FRAME_N;
  localparam int B0 = 20;
  localparam int BI = 6;
  localparam int BM = 28;
`endif
  localparam int BL = 65;
  localparam int RST_BEAT = (NB > 10) ? 10 : NB / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_readout_if bus ();

  conv_readout dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  bit   m_mode, m_cap, m_ovf, m_done;
  int   m_bi;
  pix_t m_fill[$];
  pix_t m_beats[$];
  int   k = 0;
  logic [7:0] acc_log[$];
  int   n_last, n_done;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_win(int c);
    for (int r = 0; r < OUT_W; r++)
      for (int cc = 0; cc < OUT_W; cc++)
        if (c == FIRST_CNT + r * IMG_W + cc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] mx(logic [7:0] a, logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t pm(pix_t a, pix_t b);
    pix_t r;
    r.d1 = mx(a.d1, b.d1);
    r.d2 = mx(a.d2, b.d2);
    r.d3 = mx(a.d3, b.d3);
    return r;
  endfunction

  function automatic bit rdy(int rm);
    case (rm)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      2:       return 1'b0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic m_reset();
    m_mode = 0; m_cap = 0; m_ovf = 0; m_done = 0; m_bi = 0;
    m_fill.delete();
    m_beats.delete();
  endtask

  task automatic build_frame();
    m_beats.delete();
`ifdef CONV_READOUT_POOL_EN
    for (int i = 0; i < OUT_W / 2; i++)
      for (int j = 0; j < OUT_W / 2; j++) begin
        int b;
        b = 2 * i * OUT_W + 2 * j;
        m_beats.push_back(pm(pm(m_fill[b], m_fill[b + 1]),
                             pm(m_fill[b + OUT_W], m_fill[b + OUT_W + 1])));
      end
`else
    foreach (m_fill[i]) m_beats.push_back(m_fill[i]);
`endif
  endtask

  // one clock: drive, compare, advance model, wait for next negedge
  task automatic cycle(input bit v, input int c, input pix_t d, input bit r);
    pix_t e;
    bit nd;
    bus.in_vld  = v;
    bus.cnt     = CNT_W'(c);
    bus.conv_D1 = d.d1;
    bus.conv_D2 = d.d2;
    bus.conv_D3 = d.d3;
    bus.out_rdy = r;
    #1;
    e = m_mode ? m_beats[m_bi] : '0;
    chk("vld", 32'(bus.out_vld), 32'(m_mode));
    chk("last", 32'(bus.out_last), 32'(m_mode && (m_bi == NB - 1)));
    chk("d1", 32'(bus.out_D1), 32'(e.d1));
    chk("d2", 32'(bus.out_D2), 32'(e.d2));
    chk("d3", 32'(bus.out_D3), 32'(e.d3));
    chk("done", 32'(bus.frame_done), 32'(m_done));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    if (bus.out_vld && r) begin
      acc_log.push_back(bus.out_D1);
      if (bus.out_last) n_last++;
    end
    if (bus.frame_done) n_done++;
    nd = 0;
    if (!m_mode) begin
      if (m_cap) begin
        m_fill.push_back(d);
        if (m_fill.size() == FRAME_N) begin
          build_frame();
          m_fill.delete();
          m_mode = 1;
          m_bi = 0;
        end
      end
    end else begin
      if (m_cap) m_ovf = 1;
      if (r) begin
        if (m_bi == NB - 1) begin
          m_mode = 0; m_bi = 0; nd = 1;
        end else m_bi++;
      end
    end
    m_done = nd;
    m_cap = v && in_win(c);
    k++;
    @(negedge clk);
  endtask

  task automatic sweep(input int ofs, input bit rnd, input int sk_lo,
                       input int sk_hi, input int rm);
    pix_t prev, cur;
    prev = '0;
    for (int c = 0; c <= 68; c++) begin
      if (rnd) begin
        cur.d1 = 8'($urandom);
        cur.d2 = 8'($urandom);
        cur.d3 = 8'($urandom);
      end else begin
        cur.d1 = 8'(c + ofs);
        cur.d2 = 8'(c + ofs + 1);
        cur.d3 = 8'(c + ofs + 2);
      end
      cycle(!(c >= sk_lo && c <= sk_hi), c, prev, rdy(rm));
      prev = cur;
    end
  endtask

  task automatic drain(input int rm);
    int n;
    n = 0;
    while ((m_mode || m_done) && n < 500) begin
      cycle(1'b0, 0, '0, rdy(rm));
      n++;
    end
    chk("drain_idle", 32'(bus.out_vld), 32'd0);
  endtask

  task automatic do_reset();
    bus.in_vld = 0; bus.out_rdy = 0; bus.cnt = '0;
    bus.conv_D1 = '0; bus.conv_D2 = '0; bus.conv_D3 = '0;
    rst = 1'b1;
    #1;
    chk("rst_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_d1", 32'(bus.out_D1), 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clr_log();
    acc_log.delete();
    n_last = 0;
    n_done = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_reset();
    @(negedge clk);
    do_reset();

    // directed ramp, always ready
    clr_log();
    sweep(0, 1'b0, -1, -1, 0);
    drain(0);
    chk("t1_beats", 32'(acc_log.size()), 32'(NB));
    if (acc_log.size() == NB) begin
      chk("t1_b0", 32'(acc_log[0]), 32'(B0));
      chk("t1_bmid", 32'(acc_log[BI]), 32'(BM));
      chk("t1_blast", 32'(acc_log[NB - 1]), 32'(BL));
    end
    chk("t1_last_n", 32'(n_last), 32'd1);
    chk("t1_done_n", 32'(n_done), 32'd1);
    chk("t1_ovf", 32'(bus.ovf), 32'd0);

    // 1,0,0,1 ready pattern
    clr_log();
    sweep(3, 1'b0, -1, -1, 1);
    drain(1);
    chk("t2_beats", 32'(acc_log.size()), 32'(NB));
    chk("t2_last_n", 32'(n_last), 32'd1);

    // random data, random ready
    clr_log();
    sweep(0, 1'b1, -1, -1, 3);
    drain(3);
    chk("t2r_beats", 32'(acc_log.size()), 32'(NB));

    // second frame arrives while stalled in READ
    clr_log();
    sweep(0, 1'b0, -1, -1, 2);
    sweep(100, 1'b0, -1, -1, 2);
    chk("t4_ovf", 32'(bus.ovf), 32'd1);
    drain(0);
    chk("t4_beats", 32'(acc_log.size()), 32'(NB));
    if (acc_log.size() > 0) chk("t4_b0", 32'(acc_log[0]), 32'(B0));
    chk("t4_ovf_sticky", 32'(bus.ovf), 32'd1);

    // asynchronous reset during READ
    sweep(7, 1'b0, -1, -1, 2);
    for (int i = 0; i < RST_BEAT; i++) cycle(1'b0, 0, '0, 1'b1);
    chk("t5_pre_vld", 32'(bus.out_vld), 32'd1);
    chk("t5_pre_ovf", 32'(bus.ovf), 32'd1);
    do_reset();
    clr_log();
    sweep(50, 1'b0, -1, -1, 0);
    drain(0);
    chk("t5_beats", 32'(acc_log.size()), 32'(NB));
    if (acc_log.size() > 0) chk("t5_b0", 32'(acc_log[0]), 32'(B0 + 50));

    // skipped samples leave a partial frame waiting
    do_reset();
    sweep(0, 1'b1, 30, 31, 0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 0, '0, 1'b1);
    chk("t3_partial", 32'(bus.out_vld), 32'd0);
    clr_log();
    sweep(0, 1'b1, -1, -1, 0);
    drain(0);
    chk("t3_done_n", 32'(n_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/conv_readout.md
Name: conv_readout

Overview:
- Reader-side counterpart of the conv result storage registers.
- Captures the per-cycle 3-channel conv results while the sequencer counter is inside the valid output windows, buffering one full 6x6 frame per channel.
- Once the frame is complete, streams it out to the next stage (pool/FC) over a valid/ready handshake.
- Sits between the conv storage registers and the downstream layer.

Parameters:
- DATA_W, 8, width of each channel sample.
- IMG_W, 8, input row stride in counter ticks.
- OUT_W, 6, conv output rows/cols per frame (frame = OUT_W*OUT_W beats).
- FIRST_CNT, 20, counter value of the first valid conv output.
- CNT_W, 7, counter width (covers 0..68).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_vld  in  1  sequencer data-valid qualifier.
- cnt  in  CNT_W  sequencer step counter.
- conv_D1  in  DATA_W  channel 1 from storage register.
- conv_D2  in  DATA_W  channel 2 from storage register.
- conv_D3  in  DATA_W  channel 3 from storage register.
- out_rdy  in  1  downstream ready.
- out_vld  out  1  output beat valid.
- out_D1  out  DATA_W  channel 1 output.
- out_D2  out  DATA_W  channel 2 output.
- out_D3  out  DATA_W  channel 3 output.
- out_last  out  1  final beat of frame.
- frame_done  out  1  one-cycle pulse after the last beat is accepted.
- ovf  out  1  sticky: a capture arrived while the block was not filling.

Behaviour:
- Reset (async, rst=1): state=FILL, wr_ptr=0, rd_ptr=0, cap_q=0, ovf=0; all outputs 0; buffer contents don't-care.
- Window: win = (cnt >= FIRST_CNT) && row = (cnt-FIRST_CNT)/IMG_W < OUT_W && col = (cnt-FIRST_CNT)%IMG_W < OUT_W. Defaults give 20-25, 28-33, ..., 60-65.
- Capture timing: cap_q <= in_vld && win. The storage register updates on the window edge, so data is sampled one cycle later, when cap_q=1.
- FILL state, cap_q=1: buf[wr_ptr] <= {conv_D1, conv_D2, conv_D3}; wr_ptr++. On the write with wr_ptr = OUT_W*OUT_W-1: wr_ptr->0, next state READ.
- READ state:
  - out_vld=1; out_Dx = buf[rd_ptr] (registered-index mux).
  - out_last = (rd_ptr == last index).
  - Data and out_vld are held stable while out_rdy=0.
  - Beat accepted when out_vld && out_rdy; rd_ptr++.
  - On the last accepted beat: rd_ptr->0, state FILL, frame_done=1 for the next cycle, out_vld=0 the next cycle.
- Latency: out_vld rises the cycle after the 36th write; the first beat can be accepted in that same cycle.
- Overflow: cap_q=1 while in READ drops the write, buffer unchanged, ovf <= 1 (sticky until rst). This includes the cycle in which the last beat is accepted.
- in_vld=0 inside the window: no capture, wr_ptr holds. A partial frame waits indefinitely.
- Counter restart mid-FILL: no special handling; wr_ptr continues.
- Reset mid-READ: aborts the stream, out_vld drops immediately (async), partial frame discarded.
- Output order: row-major, index = row*OUT_W + col; all three channels in parallel per beat.
- Arithmetic: unsigned compare/subtract on cnt at CNT_W bits. Pointers are $clog2(OUT_W*OUT_W) bits and wrap explicitly at the frame size, not at 2^n.

Optional Feature:
- Macro: CONV_READOUT_POOL_EN.
- Defined: the READ state emits (OUT_W/2)^2 = 9 beats. Each beat is the per-channel unsigned max of the 2x2 block at rows 2i..2i+1, cols 2j..2j+1, in row-major (i,j) order. out_last is on beat 8. Capture and handshake are unchanged.
- Undefined: 36 raw beats as above; no comparator logic is synthesized.

Decomposition:
- Package conv_pkg:
  - DATA_W, IMG_W, OUT_W, FIRST_CNT, CNT_W, FRAME_N = OUT_W*OUT_W.
  - State typedef {FILL, READ}.
  - Pixel triple struct {d1, d2, d3}.
- Sub-module conv_win_decode: combinational cnt -> win/row/col. Reusable by the storage side so both ends share one window definition.

Test Plan:
- Reset, then cnt sweeps 0..68 with in_vld=1 and conv_Dx = cnt, cnt+1, cnt+2 (delayed one cycle as the storage register does), out_rdy=1 -> 36 beats; beat 0 D1=20, beat 6 D1=28, beat 35 D1=65; out_last only on beat 35; frame_done one pulse; ovf=0.
- Same frame with out_rdy toggled 1,0,0,1 repeatedly -> no beat lost or duplicated; data stable while stalled; 36 accepts total.
- in_vld=0 at cnt 30..31 -> those two samples skipped; after one sweep only 34 writes, out_vld stays 0 until the next frame supplies 2 more.
- Second frame started while READ with out_rdy=0 -> ovf rises at the first cap_q and stays 1; streamed data equals frame 1.
- rst asserted at the 10th READ beat -> out_vld, out_last and ovf go 0 asynchronously; next full frame streams from index 0.
- With CONV_READOUT_POOL_EN and the sweep of test 1 -> 9 beats; beat 0 D1=29 (max of 20, 21, 28, 29); beat 8 D1=65; out_last on beat 8.
